cvxif_commit_result_buffer: RTL

- In-order buffer on the coprocessor side of the CoreV-X-Interface, directly downstream of the issue/commit channels.
- Stores each accepted offloaded instruction with its precomputed result and waits for the matching commit.
- Emits a result transaction for every committed entry, in issue order, over a valid/ready result channel.
- Silently drops killed entries.
- Used as the RTL reference responder behind the cvxif slave agent.

---
 rtl/cvxif_commit_result_buffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cvxif_commit_result_buffer.sv
// In-order commit/result buffer for the coprocessor side of the CoreV-X-Interface.
// Holds issued instructions with precomputed results until commit or kill, then retires them in issue order.
module cvxif_commit_result_buffer #(
  parameter int X_ID_WIDTH = 4,
  parameter int X_RFW      = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [X_ID_WIDTH-1:0]   issue_id,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_we,
  input  logic [X_RFW-1:0]        issue_data,
  input  logic                    commit_valid,
  input  logic [X_ID_WIDTH-1:0]   commit_id,
  input  logic                    commit_kill,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [X_ID_WIDTH-1:0]   result_id,
  output logic [4:0]              result_rd,
  output logic                    result_we,
  output logic [X_RFW-1:0]        result_data,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    err_unknown_commit,
  output logic                    err_dup_id
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_PENDING   = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } ent_state_e;

  ent_state_e            r_state [DEPTH];
  logic [X_ID_WIDTH-1:0] r_id    [DEPTH];
  logic [4:0]            r_rd    [DEPTH];
  logic                  r_we    [DEPTH];
  logic [X_RFW-1:0]      r_data  [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_issue_ready;
  logic          r_err_unknown;
  logic          r_err_dup;

  logic [DEPTH-1:0] w_pend_match;
  logic [DEPTH-1:0] w_dup_hit;
  logic [DEPTH-1:0] w_age_match;
  logic             w_found;
  logic [PW-1:0]    w_hit_idx;
  logic             w_issue_fire;
  logic             w_commit_new;
  logic             w_retire;
  logic             w_head_committed;
  logic             w_head_killed;
  logic [CW-1:0]    w_count_next;
  ent_state_e       w_commit_state;

  // Per-entry comparators; w_age_match reorders the pending matches oldest-first starting at head.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign w_pend_match[gi] = (r_state[gi] == ST_PENDING) && (r_id[gi] == commit_id);
      assign w_dup_hit[gi]    = (r_state[gi] != ST_FREE) && (r_id[gi] == issue_id);
      assign w_age_match[gi]  = w_pend_match[r_head + PW'(gi)];
    end
  endgenerate

  always_comb begin
    w_found   = 1'b0;
    w_hit_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_age_match[k]) begin
        w_found   = 1'b1;
        w_hit_idx = r_head + PW'(k);
      end
    end
  end

  assign w_issue_fire     = issue_valid && r_issue_ready;
  // A same-cycle commit may target the entry being written only if no older pending entry claims it.
  assign w_commit_new     = commit_valid && !w_found && w_issue_fire && (issue_id == commit_id);
  assign w_commit_state   = commit_kill ? ST_KILLED : ST_COMMITTED;
  assign w_head_committed = (r_state[r_head] == ST_COMMITTED);
  assign w_head_killed    = (r_state[r_head] == ST_KILLED);
  assign w_retire         = w_head_killed || (w_head_committed && result_ready);

  always_comb begin
    w_count_next = r_count;
    case ({w_issue_fire, w_retire})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_FREE;
        r_id[i]    <= '0;
        r_rd[i]    <= '0;
        r_we[i]    <= 1'b0;
        r_data[i]  <= '0;
      end
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_issue_ready <= 1'b0;
      r_err_unknown <= 1'b0;
      r_err_dup     <= 1'b0;
    end else begin
      // Retiring head, matched pending entry and the free tail slot are always distinct entries.
      if (w_retire) begin
        r_state[r_head] <= ST_FREE;
        r_head          <= r_head + PW'(1);
      end
      if (commit_valid && w_found) begin
        r_state[w_hit_idx] <= w_commit_state;
      end
      if (w_issue_fire) begin
        r_state[r_tail] <= w_commit_new ? w_commit_state : ST_PENDING;
        r_id[r_tail]    <= issue_id;
        r_rd[r_tail]    <= issue_rd;
        r_we[r_tail]    <= issue_we;
        r_data[r_tail]  <= issue_data;
        r_tail          <= r_tail + PW'(1);
      end
      r_count       <= w_count_next;
      r_issue_ready <= (w_count_next != CW'(DEPTH));
      r_err_unknown <= commit_valid && !w_found && !w_commit_new;
      r_err_dup     <= w_issue_fire && (|w_dup_hit);
    end
  end

  assign issue_ready        = r_issue_ready;
  assign result_valid       = w_head_committed;
  assign result_id          = r_id[r_head];
  assign result_rd          = r_rd[r_head];
  assign result_we          = r_we[r_head];
  assign result_data        = r_data[r_head];
  assign occupancy          = r_count;
  assign err_unknown_commit = r_err_unknown;
  assign err_dup_id         = r_err_dup;

endmodule
